// File: rtl/flood_pkg.sv
// flood_pkg: shared state, seed and LFSR tap constants for board
// and move generation blocks.
package flood_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    DONE,
    HOLD
  } state_t;

  localparam logic [15:0] DEFAULT_SEED = 16'hDAD7;
  localparam int MIN_SIZE = 2;
  localparam int MIN_COLORS = 2;

  // Bit i set means x^(i+1) is a term of the feedback polynomial.
  function automatic logic [63:0] lfsr_taps(input int w);
    logic [63:0] t;
    t = 64'h0;
    unique case (w)
      4:  t = 64'hC;
      8:  t = 64'hB8;
      12: t = 64'hE08;
      16: t = 64'hB400;
      24: t = 64'hE10000;
      32: t = 64'h80200003;
      default: t = (64'd1 << (w - 1)) | 64'd1;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_fib.sv
// lfsr_fib: Fibonacci LFSR, shift-left, feedback into bit 0.
// Load has priority over step.
module lfsr_fib #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS = 16'hB400
) (
  input  logic             CLOCK,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             step,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge CLOCK) begin
    if (load) begin
      value <= seed;
    end else if (step) begin
      value <= {value[WIDTH-2:0], ^(value & TAPS)};
    end
  end

endmodule

// File: rtl/board_gen.sv
// board_gen: fills a SIZE x SIZE board row-major with LFSR colours.
// Define BOARD_GEN_REJECT_EN for rejection sampling (uniform colours).
module board_gen
  import flood_pkg::*;
#(
  parameter int MAX_SIZE = 26,
  parameter int COLOR_W  = 3,
  parameter int LFSR_W   = 16
) (
  input  logic                            CLOCK,
  input  logic                            RESET_N,
  input  logic                            START,
  input  logic [LFSR_W-1:0]               SEED,
  input  logic [$clog2(MAX_SIZE+1)-1:0]   SIZE,
  input  logic [COLOR_W:0]                COLOR_NUM,
  output logic                            WR_EN,
  output logic [$clog2(MAX_SIZE)-1:0]     WR_ROW,
  output logic [$clog2(MAX_SIZE)-1:0]     WR_COL,
  output logic [COLOR_W-1:0]              WR_COLOR,
  output logic                            BUSY,
  output logic                            BOARD_READY,
  output logic                            CFG_ERR
);

  localparam int SW = $clog2(MAX_SIZE + 1);
  localparam int PW = $clog2(MAX_SIZE);
  localparam int CW = COLOR_W + 1;
  localparam int PRW = 8 + CW;

  localparam logic [63:0] TAPS64 = lfsr_taps(LFSR_W);
  localparam logic [LFSR_W-1:0] TAPS = TAPS64[LFSR_W-1:0];
  localparam logic [LFSR_W-1:0] SEED_DEF = LFSR_W'(DEFAULT_SEED);

  localparam logic [SW-1:0] SIZE_LO = SW'(MIN_SIZE);
  localparam logic [SW-1:0] SIZE_HI = SW'(MAX_SIZE);
  localparam logic [CW-1:0] COL_LO = CW'(MIN_COLORS);
  localparam logic [CW-1:0] COL_HI = CW'(2 ** COLOR_W);

  state_t            state;
  logic [SW-1:0]     size_q;
  logic [CW-1:0]     ncol_q;
  logic [PW-1:0]     row_q;
  logic [PW-1:0]     col_q;

  logic [LFSR_W-1:0] r_val;
  logic [LFSR_W-1:0] lfsr_seed;
  logic              lfsr_load;
  logic              lfsr_step;

  logic              cfg_ok;
  logic              start_ok;
  logic [CW-1:0]     cand;
  logic              accept;
  logic              last_col;
  logic              last_row;

  assign cfg_ok = (SIZE >= SIZE_LO) && (SIZE <= SIZE_HI) &&
                  (COLOR_NUM >= COL_LO) && (COLOR_NUM <= COL_HI);

  assign start_ok = (state == IDLE) && START && cfg_ok;

  // Reset reuses the load path so the register restarts at the default seed.
  assign lfsr_load = !RESET_N || start_ok;
  assign lfsr_seed = (!RESET_N || SEED == '0) ? SEED_DEF : SEED;
  assign lfsr_step = (state == GEN);

  lfsr_fib #(
    .WIDTH (LFSR_W),
    .TAPS  (TAPS)
  ) u_lfsr (
    .CLOCK (CLOCK),
    .load  (lfsr_load),
    .seed  (lfsr_seed),
    .step  (lfsr_step),
    .value (r_val)
  );

`ifdef BOARD_GEN_REJECT_EN
  assign cand   = {1'b0, r_val[COLOR_W-1:0]};
  assign accept = (cand < ncol_q);
`else
  logic [PRW-1:0] prod;
  assign prod   = PRW'(r_val[7:0]) * PRW'(ncol_q);
  assign cand   = prod[PRW-1:8];
  assign accept = 1'b1;
`endif

  logic unused_bits;
  assign unused_bits = ^{r_val, cand};

  assign last_col = (SW'(col_q) == size_q - SW'(1));
  assign last_row = (SW'(row_q) == size_q - SW'(1));

  assign BUSY = (state == GEN);

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state       <= IDLE;
      size_q      <= '0;
      ncol_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      WR_EN       <= 1'b0;
      WR_ROW      <= '0;
      WR_COL      <= '0;
      WR_COLOR    <= '0;
      BOARD_READY <= 1'b0;
      CFG_ERR     <= 1'b0;
    end else begin
      WR_EN   <= 1'b0;
      CFG_ERR <= 1'b0;
      unique case (state)
        IDLE: begin
          BOARD_READY <= 1'b0;
          if (START) begin
            if (cfg_ok) begin
              state  <= GEN;
              size_q <= SIZE;
              ncol_q <= COLOR_NUM;
              row_q  <= '0;
              col_q  <= '0;
            end else begin
              CFG_ERR <= 1'b1;
              state   <= HOLD;
            end
          end
        end
        GEN: begin
          if (!START) begin
            state <= IDLE;
          end else if (accept) begin
            WR_EN    <= 1'b1;
            WR_ROW   <= row_q;
            WR_COL   <= col_q;
            WR_COLOR <= cand[COLOR_W-1:0];
            if (last_col) begin
              col_q <= '0;
              if (last_row) begin
                state <= DONE;
              end else begin
                row_q <= row_q + PW'(1);
              end
            end else begin
              col_q <= col_q + PW'(1);
            end
          end
        end
        DONE: begin
          // Ready rises one cycle after the last write, never alongside it.
          BOARD_READY <= 1'b1;
          if (!START && BOARD_READY) begin
            state       <= IDLE;
            BOARD_READY <= 1'b0;
          end
        end
        HOLD: begin
          if (!START) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/board_gen.md
BOARD_GEN -- requirements
Module: board_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  MAX_SIZE  26  largest board edge, in cells
  COLOR_W   3   width of the colour index
  LFSR_W    16  width of the pseudo-random register
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  CLOCK      in   1                       system clock
  RESET_N    in   1                       reset: synchronous, active-low
  START      in   1                       level request to generate a board
  SEED       in   LFSR_W                  LFSR seed; 0 selects the default seed
  SIZE       in   $clog2(MAX_SIZE+1)      board edge for this run
  COLOR_NUM  in   COLOR_W+1               number of colours for this run
  WR_EN      out  1                       one-cycle cell write strobe
  WR_ROW     out  $clog2(MAX_SIZE)        row of the written cell
  WR_COL     out  $clog2(MAX_SIZE)        column of the written cell
  WR_COLOR   out  COLOR_W                 colour of the written cell
  BUSY       out  1                       generation in progress
  BOARD_READY out 1                       board complete
  CFG_ERR    out  1                       one-cycle pulse: START rejected, configuration illegal

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, GEN, DONE, HOLD.
REQ-004 IDLE with START=1 SHALL check the configuration: SIZE must be in 2..MAX_SIZE and COLOR_NUM in 2..2^COLOR_W.
REQ-005 If the configuration is illegal, the block SHALL pulse CFG_ERR for one cycle and enter HOLD.
REQ-006 If the configuration is legal, the block SHALL enter GEN and latch SIZE and COLOR_NUM.
REQ-007 On the same legal START it SHALL load R with SEED, or with 16'hDAD7 (zero-extended or truncated to LFSR_W) when SEED==0, and clear the row and column counters.
REQ-008 Every GEN cycle SHALL advance the Fibonacci LFSR: R <= {R[LFSR_W-2:0], ^(R & TAPS)}.
REQ-009 For LFSR_W=16, TAPS SHALL be 16'hB400 (x^16+x^14+x^13+x^11+1).
REQ-010 The colour candidate SHALL be derived from R before that cycle's advance.
REQ-011 The default candidate mapping SHALL be (R[7:0]*COLOR_NUM)>>8, a 12-bit product whose result is always < COLOR_NUM.
REQ-012 An accepted candidate SHALL assert WR_EN for one cycle with the current row, column and colour.
REQ-013 Column SHALL increment on each write; at SIZE-1 the column SHALL wrap to 0 and the row SHALL increment.
REQ-014 Writes SHALL be row-major, one cell per accepted cycle, with no bubbles in default mode, so that GEN lasts exactly SIZE*SIZE cycles.
REQ-015 After the write of cell (SIZE-1,SIZE-1) the FSM SHALL enter DONE; BOARD_READY SHALL be high from the next cycle.
REQ-016 BOARD_READY SHALL stay high in DONE until START=0; the block then returns to IDLE with BOARD_READY cleared the cycle after.
REQ-017 HOLD SHALL return to IDLE once START=0, so that a held START never retriggers.
REQ-018 START falling during GEN SHALL abort the run: return to IDLE next cycle, issue no further writes, and never assert BOARD_READY.
REQ-019 BUSY SHALL be 1 exactly in GEN.
REQ-020 WR_EN, BOARD_READY and CFG_ERR SHALL never be high in the same cycle.

Reset
REQ-021 RESET_N=0 at a CLOCK edge SHALL force IDLE and clear all of: outputs, counters, latched configuration.
REQ-022 The same reset SHALL set R to the default seed.
REQ-023 Reset during GEN SHALL take effect at the next edge; no WR_EN shall follow it.

Configuration
REQ-024 Macro BOARD_GEN_REJECT_EN defined: candidate = R[COLOR_W-1:0].
REQ-025 With BOARD_GEN_REJECT_EN, a candidate >= COLOR_NUM SHALL be discarded: no write that cycle, counters held, LFSR still advances.
REQ-026 With BOARD_GEN_REJECT_EN, GEN therefore takes at least SIZE*SIZE cycles and the colour distribution is uniform.
REQ-027 Macro undefined: the REQ-011 scaled mapping SHALL apply and every GEN cycle SHALL write.

Structure
REQ-028 Package flood_pkg SHALL hold: the state enum, DEFAULT_SEED, LFSR TAPS per LFSR_W, and the MIN_SIZE=2 and MIN_COLORS=2 constants.
REQ-029 The LFSR SHALL be a sub-module lfsr_fib (parameters WIDTH and TAPS; ports load, seed, step, value), reused by later move-generation blocks.

Verification
REQ-030 Default mode, SEED=16'h0001, SIZE=4, COLOR_NUM=8, START held -> the first write is (0,0,colour 0); 16 writes follow in 16 consecutive cycles; BOARD_READY is high on cycle 17.
REQ-031 BOARD_GEN_REJECT_EN, SEED=16'h0001, COLOR_NUM=8 -> the first write is (0,0,colour 1), with no rejections.
REQ-032 BOARD_GEN_REJECT_EN, COLOR_NUM=3, SIZE=26 -> exactly 676 writes; all colours < 3; each colour count is within 10% of 225.
REQ-033 SEED=0 versus SEED=16'hDAD7 -> identical write streams.
REQ-034 SIZE=1 or COLOR_NUM=9 -> a single CFG_ERR pulse and no WR_EN; no retrigger until START has been low for one cycle.
REQ-035 START dropped after 5 writes, or RESET_N=0 mid-GEN -> no further WR_EN; BUSY=0 and BOARD_READY=0 on the next cycle.
